// File: rtl/k423_if_pcgen.sv
// IF-stage fetch PC generator: IDLE/REQ/WAIT/OUT/DROP sequencer, one imem request outstanding, 3 cycles/instr at zero-wait.
// IF/ID stalls hold OUT with all state frozen; backend redirects win. Optional counters under K423_IF_PCGEN_PERF_EN.
module k423_if_pcgen #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              redir_vld_i,
  input  logic [ADDR_W-1:0] redir_pc_i,
  output logic              imem_req_vld_o,
  input  logic              imem_req_rdy_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_rsp_vld_i,
  input  logic [DATA_W-1:0] imem_rsp_data_i,
  output logic [ADDR_W-1:0] bpu_pc_o,
  output logic [DATA_W-1:0] bpu_inst_o,
  input  logic              bpu_prd_tkn_i,
  input  logic [ADDR_W-1:0] bpu_prd_pc_i,
  input  logic [1:0]        bpu_prd_sat_cnt_i,
  output logic              if_vld_o,
  input  logic              if_rdy_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_prd_tkn_o,
  output logic [ADDR_W-1:0] if_prd_pc_o,
  output logic [1:0]        if_prd_sat_cnt_o
`ifdef K423_IF_PCGEN_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_redir_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DROP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [DATA_W-1:0] r_inst;
  logic              w_inst_we;
  logic              w_req_vld;
  logic              w_if_vld;
  logic              w_fire;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_pc    <= BOOT_ADDR;
      r_inst  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_inst_we) begin
        r_inst <= imem_rsp_data_i;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_we   = 1'b0;
    w_req_vld   = 1'b0;
    w_if_vld    = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        w_req_vld = 1'b1;
        // An accepted request still owes a response, so a redirect must drain it in DROP.
        if (imem_req_rdy_i) begin
          w_state_nxt = redir_vld_i ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (redir_vld_i) begin
          w_state_nxt = imem_rsp_vld_i ? S_REQ : S_DROP;
        end else if (imem_rsp_vld_i) begin
          w_inst_we   = 1'b1;
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        w_if_vld = ~redir_vld_i;
        w_fire   = w_if_vld & if_rdy_i;
        if (redir_vld_i || w_fire) begin
          w_state_nxt = S_REQ;
        end
        if (w_fire) begin
          w_pc_nxt = bpu_prd_tkn_i ? bpu_prd_pc_i : r_pc + ADDR_W'(4);
        end
      end
      S_DROP: begin
        if (imem_rsp_vld_i) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (redir_vld_i) begin
      w_pc_nxt = redir_pc_i;
    end
  end

  assign imem_req_vld_o   = w_req_vld;
  assign imem_req_addr_o  = r_pc;
  assign bpu_pc_o         = r_pc;
  assign bpu_inst_o       = r_inst;
  assign if_vld_o         = w_if_vld;
  assign if_pc_o          = r_pc;
  assign if_inst_o        = r_inst;
  assign if_prd_tkn_o     = bpu_prd_tkn_i;
  assign if_prd_pc_o      = bpu_prd_pc_i;
  assign if_prd_sat_cnt_o = bpu_prd_sat_cnt_i;

`ifdef K423_IF_PCGEN_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_redir;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_perf_fetch <= '0;
      r_perf_redir <= '0;
    end else begin
      if (w_fire && (r_perf_fetch != 32'hFFFF_FFFF)) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (redir_vld_i && (r_perf_redir != 32'hFFFF_FFFF)) begin
        r_perf_redir <= r_perf_redir + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o = r_perf_fetch;
  assign perf_redir_cnt_o = r_perf_redir;
`endif

endmodule

// File: doc/k423_if_pcgen.md
Name: k423_if_pcgen

Overview:
Fetch PC generator and instruction-fetch sequencer for the IF stage, sitting directly upstream of the branch predict unit.
- Owns the architectural fetch PC and issues single-outstanding requests to instruction memory.
- Registers the returned word and presents PC and instruction to the BPU and mini-decode.
- Consumes the BPU prediction to choose the next fetch PC, and hands the instruction plus prediction to IF/ID through a valid/ready handshake.
- Backend redirects (mispredict or exception) override everything.

Parameters:
ADDR_W, 32, fetch address width (matches CORE_ADDR_W)
DATA_W, 32, instruction word width (matches CORE_DATA_W)
BOOT_ADDR, 32'h8000_0000, fetch PC after reset

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
redir_vld_i  in  1  backend redirect request
redir_pc_i  in  ADDR_W  redirect target
imem_req_vld_o  out  1  fetch request valid
imem_req_rdy_i  in  1  imem accepts request
imem_req_addr_o  out  ADDR_W  fetch address
imem_rsp_vld_i  in  1  fetch response valid (always accepted)
imem_rsp_data_i  in  DATA_W  fetched instruction
bpu_pc_o  out  ADDR_W  PC presented to BPU and mini-decode
bpu_inst_o  out  DATA_W  instruction presented to BPU and mini-decode
bpu_prd_tkn_i  in  1  BPU predicted-taken (combinational from bpu_pc_o/bpu_inst_o)
bpu_prd_pc_i  in  ADDR_W  BPU predicted target
bpu_prd_sat_cnt_i  in  2  BPU saturating counter
if_vld_o  out  1  instruction valid to IF/ID
if_rdy_i  in  1  IF/ID ready
if_pc_o  out  ADDR_W  instruction PC
if_inst_o  out  DATA_W  instruction
if_prd_tkn_o  out  1  prediction carried down pipe
if_prd_pc_o  out  ADDR_W  predicted target carried down
if_prd_sat_cnt_o  out  2  counter carried down for update

Behaviour:
- State register FSM with states IDLE, REQ, WAIT, OUT, DROP. Registers: pc_q (fetch PC) and inst_q.
- Reset:
  - state=IDLE, pc_q=BOOT_ADDR, inst_q=0.
  - All outputs 0, except imem_req_addr_o/bpu_pc_o/if_pc_o, which equal BOOT_ADDR.
- Port mapping: imem_req_addr_o=pc_q; bpu_pc_o=if_pc_o=pc_q; bpu_inst_o=if_inst_o=inst_q; if_prd_* = bpu_prd_* passthrough.
- IDLE: outputs quiet; next cycle REQ. Any imem_rsp_vld_i is ignored.
- REQ: imem_req_vld_o=1. On imem_req_rdy_i go to WAIT.
- WAIT: on imem_rsp_vld_i, inst_q<=imem_rsp_data_i and go to OUT.
- OUT:
  - if_vld_o = ~redir_vld_i.
  - On if_vld_o & if_rdy_i: pc_q <= bpu_prd_tkn_i ? bpu_prd_pc_i : pc_q+4, wrapping mod 2^ADDR_W, then go to REQ.
  - Otherwise hold all registers stable.
- Throughput: 1 instruction per 3 cycles with a zero-wait imem. Exactly one request is outstanding at any time.
- Redirect (highest priority, any state); pc_q<=redir_pc_i in every case:
  - IDLE: go to REQ.
  - REQ with rdy=0: stay in REQ; the address changes next cycle, which is legal because the request was not accepted.
  - REQ with rdy=1: the old request is accepted, so go to DROP.
  - WAIT with rsp_vld=0: go to DROP.
  - WAIT with rsp_vld=1: discard the response and go to REQ.
  - OUT: if_vld_o is forced 0 and the instruction is dropped; go to REQ.
  - DROP: if rsp_vld=1 go to REQ, else stay in DROP. A later redirect overwrites pc_q.
- DROP: imem_req_vld_o=0. The first imem_rsp_vld_i is discarded (inst_q is not written), then go to REQ.
- Redirect target alignment is not checked; bits[1:0] pass through unchanged.
- Async reset mid-transaction returns to IDLE. The imem must be reset in the same domain; stale responses in IDLE are ignored.

Optional Feature:
Macro K423_IF_PCGEN_PERF_EN.
- When defined, adds outputs perf_fetch_cnt_o[31:0] and perf_redir_cnt_o[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - perf_fetch_cnt_o increments on each if_vld_o & if_rdy_i.
  - perf_redir_cnt_o increments on each cycle with redir_vld_i=1.
- When undefined, the ports and logic are absent. Functional behaviour is identical either way.

Test Plan:
- Reset release, imem rdy=1, rsp one cycle after accept, if_rdy=1, bpu_prd_tkn=0:
  - first request addr 0x8000_0000; if_vld with pc 0x8000_0000 in cycle 3.
  - next request addr 0x8000_0004.
- OUT with bpu_prd_tkn=1, bpu_prd_pc=0x8000_0100, if_rdy=1 -> next imem_req_addr_o=0x8000_0100; if_prd_tkn_o=1 and if_prd_sat_cnt_o equal the BPU values during the handshake.
- Hold if_rdy=0 for 5 cycles in OUT -> if_vld_o stays 1; if_pc_o and if_inst_o stable; no new imem request.
- Redirect to 0x8000_0200 in WAIT before the response (old data 0xDEAD_BEEF):
  - state goes to DROP; the 0xDEAD_BEEF response is never presented.
  - next request addr 0x8000_0200.
- Redirect to 0x8000_0300 in the same cycle as OUT with if_rdy=1 -> if_vld_o=0 that cycle; next request addr 0x8000_0300.
- pc_q=0xFFFF_FFFC, not taken -> next request addr 0x0000_0000. With PERF_EN, the fetch count is correct after 10 handshakes and redirects are counted.
